// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state codes, GF(2^8) helpers and the
// key-length derivations used by the iterative encryption core.
package aes_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_KEXP  = 3'd1;
  localparam logic [2:0] ST_READY = 3'd2;
  localparam logic [2:0] ST_SUB   = 3'd3;
  localparam logic [2:0] ST_MIX   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  function automatic bit key_bits_ok(input int kb);
    return (kb == 128) || (kb == 192) || (kb == 256);
  endfunction

  function automatic int nk_of(input int kb);
    return kb / 32;
  endfunction

  function automatic int nr_of(input int kb);
    return nk_of(kb) + 6;
  endfunction

  function automatic int nw_of(input int kb);
    return 4 * (nr_of(kb) + 1);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column word is {row0, row1, row2, row3}.
  function automatic logic [31:0] mixcolumn(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte 4*c+r of the block sits at bits [127-8*(4*c+r) -: 8].
  function automatic logic [127:0] shiftrows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox4.sv
// Four parallel FIPS-197 forward S-box lookups on a 32-bit word.
module aes_sbox4 (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  // Entry 0 is the leftmost byte, so entry x lives at packed index 255-x (= ~x).
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = {SBOX[~din[31:24]], SBOX[~din[23:16]], SBOX[~din[15:8]], SBOX[~din[7:0]]};

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES encryption core for 128/192/256-bit keys. The key is expanded
// once per load into a local word store and reused for every block.
//   state | meaning
//   IDLE  | no schedule present, waiting for a key
//   KEXP  | expanding the key, one word per cycle
//   READY | schedule present, waiting for a key or a block
//   SUB   | S-box applied to one state column per cycle
//   MIX   | ShiftRows, MixColumns (not in last round), AddRoundKey
//   DONE  | ciphertext presented until out_ready
module aes_enc_iter
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        plaintext,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        ciphertext,
  output logic                key_loaded,
  output logic                busy
);

  localparam int NK = nk_of(KEY_BITS);
  localparam int NR = nr_of(KEY_BITS);
  localparam int NW = nw_of(KEY_BITS);
  localparam int IW = $clog2(NW);

  if (!key_bits_ok(KEY_BITS)) begin : g_bad_key_bits
    $error("aes_enc_iter: KEY_BITS must be 128, 192 or 256");
  end

  logic [2:0]    st;
  logic [31:0]   w [NW];
  logic [IW-1:0] widx;
  logic [2:0]    kmod;
  logic [7:0]    rcon;
  logic [3:0]    round;
  logic [1:0]    col;
  logic [127:0]  blk;

  logic          key_fire;
  logic          last_round;
  logic [IW-1:0] rbase;
  logic [31:0]   wprev, col_word, sbox_in, sbox_out, ktemp;
  logic [127:0]  rk0, rk_cur, sr, mc, mix_res;

  assign key_ready  = (st == ST_IDLE) || (st == ST_READY);
  assign in_ready   = (st == ST_READY) && !key_valid;
  assign out_valid  = (st == ST_DONE);
  assign busy       = (st == ST_KEXP) || (st == ST_SUB) || (st == ST_MIX);
  assign key_fire   = key_valid && key_ready;
  assign last_round = (round == 4'(NR));

  assign wprev  = w[widx - IW'(1)];
  assign rbase  = IW'({round, 2'b00});
  assign rk0    = {w[0], w[1], w[2], w[3]};
  assign rk_cur = {w[rbase], w[rbase + IW'(1)], w[rbase + IW'(2)], w[rbase + IW'(3)]};

  always_comb begin
    col_word = blk[127:96];
    case (col)
      2'd1:    col_word = blk[95:64];
      2'd2:    col_word = blk[63:32];
      2'd3:    col_word = blk[31:0];
      default: col_word = blk[127:96];
    endcase
  end

  // KEXP and SUB never overlap, so one S-box serves both.
  always_comb begin
    sbox_in = col_word;
    if (st == ST_KEXP) sbox_in = (kmod == 3'd0) ? {wprev[23:0], wprev[31:24]} : wprev;
  end

  aes_sbox4 u_sbox (
    .din  (sbox_in),
    .dout (sbox_out)
  );

  always_comb begin
    ktemp = wprev;
    if (kmod == 3'd0)                   ktemp = sbox_out ^ {rcon, 24'h0};
    else if (NK == 8 && kmod == 3'd4)   ktemp = sbox_out;
  end

  always_comb begin
    sr      = shiftrows(blk);
    mc      = {mixcolumn(sr[127:96]), mixcolumn(sr[95:64]),
               mixcolumn(sr[63:32]), mixcolumn(sr[31:0])};
    mix_res = (last_round ? sr : mc) ^ rk_cur;
  end

  // Schedule storage needs no reset; key_loaded gates its use.
  always_ff @(posedge clk) begin
    if (key_fire) begin
      for (int k = 0; k < NK; k++) w[k] <= key_in[KEY_BITS-1-32*k -: 32];
    end else if (st == ST_KEXP) begin
      w[widx] <= w[widx - IW'(NK)] ^ ktemp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ST_IDLE;
      widx       <= '0;
      kmod       <= '0;
      rcon       <= 8'h01;
      round      <= '0;
      col        <= '0;
      blk        <= '0;
      ciphertext <= '0;
      key_loaded <= 1'b0;
    end else begin
      case (st)
        ST_IDLE, ST_READY: begin
          if (key_fire) begin
            widx       <= IW'(NK);
            kmod       <= '0;
            rcon       <= 8'h01;
            key_loaded <= 1'b0;
            st         <= ST_KEXP;
          end else if (in_valid && in_ready) begin
            blk   <= plaintext ^ rk0;
            round <= 4'd1;
            col   <= '0;
            st    <= ST_SUB;
          end
        end
        ST_KEXP: begin
          kmod <= (kmod == 3'(NK - 1)) ? 3'd0 : kmod + 3'd1;
          if (kmod == 3'd0) rcon <= xtime(rcon);
          widx <= widx + IW'(1);
          if (widx == IW'(NW - 1)) begin
            key_loaded <= 1'b1;
            st         <= ST_READY;
          end
        end
        ST_SUB: begin
          case (col)
            2'd0:    blk[127:96] <= sbox_out;
            2'd1:    blk[95:64]  <= sbox_out;
            2'd2:    blk[63:32]  <= sbox_out;
            default: blk[31:0]   <= sbox_out;
          endcase
          col <= col + 2'd1;
          if (col == 2'd3) st <= ST_MIX;
        end
        ST_MIX: begin
          blk <= mix_res;
          if (last_round) begin
            ciphertext <= mix_res;
            st         <= ST_DONE;
          end else begin
            round <= round + 4'd1;
            st    <= ST_SUB;
          end
        end
        ST_DONE: begin
          if (out_ready) st <= ST_READY;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc_iter.sv
// Bench for aes_enc_iter: one instance per key length, checked against FIPS
// vectors and a byte-level AES model with an algebraically derived S-box.
module tb_aes_enc_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_valid [3], key_ready [3], in_valid [3], in_ready [3];
  logic out_valid [3], out_ready [3], key_loaded [3], busy [3];
  logic [127:0] pt_bus [3], ct_bus [3];
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic [7:0]   sb_ref [256];
  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  aes_enc_iter #(.KEY_BITS(128)) u_aes128 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid[0]), .key_ready(key_ready[0]), .key_in(key128),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .plaintext(pt_bus[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .ciphertext(ct_bus[0]), .key_loaded(key_loaded[0]), .busy(busy[0]));
  aes_enc_iter #(.KEY_BITS(192)) u_aes192 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid[1]), .key_ready(key_ready[1]), .key_in(key192),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .plaintext(pt_bus[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .ciphertext(ct_bus[1]), .key_loaded(key_loaded[1]), .busy(busy[1]));
  aes_enc_iter #(.KEY_BITS(256)) u_aes256 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid[2]), .key_ready(key_ready[2]), .key_in(key256),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .plaintext(pt_bus[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .ciphertext(ct_bus[2]), .key_loaded(key_loaded[2]), .busy(busy[2]));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box = affine transform of the multiplicative inverse (x^254).
  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      if (v != 0) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(v));
      end
      sb_ref[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // key is left-aligned: the nk*32 key bits occupy key[255 -: nk*32].
  function automatic logic [127:0] aes_ref(input logic [255:0] key, input int nk, input logic [127:0] pt);
    logic [7:0] wb [240];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tw [4];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] res;
    int nr, nw;
    nr = nk + 6;
    nw = 4 * (nr + 1);
    for (int j = 0; j < 4*nk; j++) wb[j] = key[255-8*j -: 8];
    rc = 8'h01;
    for (int i = nk; i < nw; i++) begin
      for (int b = 0; b < 4; b++) tw[b] = wb[4*(i-1)+b];
      if (i % nk == 0) begin
        a0 = tw[0];
        tw[0] = sb_ref[tw[1]] ^ rc;
        tw[1] = sb_ref[tw[2]];
        tw[2] = sb_ref[tw[3]];
        tw[3] = sb_ref[a0];
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        for (int b = 0; b < 4; b++) tw[b] = sb_ref[tw[b]];
      end
      for (int b = 0; b < 4; b++) wb[4*i+b] = wb[4*(i-nk)+b] ^ tw[b];
    end
    for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ wb[j];
    for (int r = 1; r <= nr; r++) begin
      for (int j = 0; j < 16; j++) s[j] = sb_ref[s[j]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int j = 0; j < 16; j++) s[j] = t[j] ^ wb[16*r+j];
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_key(input int d, input logic [255:0] k);
    case (d)
      0:       key128 = k[255:128];
      1:       key192 = k[255:64];
      default: key256 = k;
    endcase
  endtask

  task automatic do_key(input int d, input logic [255:0] k, output int lat);
    int n;
    set_key(d, k);
    key_valid[d] = 1'b1;
    n = 0;
    while (!key_ready[d] && n < 200) begin tick(); n++; end
    chk($sformatf("key_ready_wait_d%0d", d), key_ready[d], 1'b1);
    tick();
    key_valid[d] = 1'b0;
    lat = 0;
    while (!key_loaded[d] && lat < 400) begin tick(); lat++; end
  endtask

  task automatic do_block(input int d, input logic [127:0] p, output int lat, output logic [127:0] c);
    int n;
    pt_bus[d] = p;
    in_valid[d] = 1'b1;
    n = 0;
    while (!in_ready[d] && n < 200) begin tick(); n++; end
    chk($sformatf("in_ready_wait_d%0d", d), in_ready[d], 1'b1);
    tick();
    in_valid[d] = 1'b0;
    lat = 0;
    while (!out_valid[d] && lat < 400) begin tick(); lat++; end
    c = ct_bus[d];
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    chk($sformatf("out_valid_drop_d%0d", d), out_valid[d], 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [127:0] c, p, p2;
    logic [255:0] k;
    for (int d = 0; d < 3; d++) begin
      key_valid[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b0; pt_bus[d] = '0;
    end
    key128 = '0; key192 = '0; key256 = '0;
    build_sbox();

    #12;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_key_ready_d%0d", d), key_ready[d], 1'b1);
      chk($sformatf("rst_in_ready_d%0d", d), in_ready[d], 1'b0);
      chk($sformatf("rst_out_valid_d%0d", d), out_valid[d], 1'b0);
      chk($sformatf("rst_ct_d%0d", d), ct_bus[d], 128'h0);
      chk($sformatf("rst_key_loaded_d%0d", d), key_loaded[d], 1'b0);
      chk($sformatf("rst_busy_d%0d", d), busy[d], 1'b0);
    end
    #11;
    rst_n = 1'b1;
    tick();

    // Block offered with no key: must never be taken.
    in_valid[0] = 1'b1;
    pt_bus[0] = 128'h3243f6a8885a308d313198a2e0370734;
    for (int n = 0; n < 20; n++) begin
      chk("nokey_in_ready", in_ready[0], 1'b0);
      chk("nokey_out_valid", out_valid[0], 1'b0);
      tick();
    end
    in_valid[0] = 1'b0;

    do_key(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, lat);
    chk("kexp_lat_128", lat, 40);
    do_block(0, 128'h3243f6a8885a308d313198a2e0370734, lat, c);
    chk("blk_lat_128", lat, 50);
    chk("fips_ct_128", c, 128'h3925841d02dc09fbdc118597196a0b32);

    do_key(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, lat);
    chk("kexp_lat_192", lat, 46);
    do_block(1, 128'h00112233445566778899aabbccddeeff, lat, c);
    chk("blk_lat_192", lat, 60);
    chk("fips_ct_192", c, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);

    do_key(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, lat);
    chk("kexp_lat_256", lat, 52);
    do_block(2, 128'h00112233445566778899aabbccddeeff, lat, c);
    chk("blk_lat_256", lat, 70);
    chk("fips_ct_256", c, 128'h8ea2b7ca516745bfeafc49904b496089);

    // Key reuse with backpressure held in DONE and a second block waiting.
    k = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    do_key(0, k, lat);
    chk("kexp_lat_bp", lat, 40);
    pt_bus[0] = 128'h00112233445566778899aabbccddeeff;
    in_valid[0] = 1'b1;
    tick();
    p2 = {$urandom, $urandom, $urandom, $urandom};
    pt_bus[0] = p2;
    lat = 0;
    while (!out_valid[0] && lat < 400) begin tick(); lat++; end
    chk("blk_lat_bp", lat, 50);
    for (int n = 0; n < 10; n++) begin
      chk("bp_ct_stable", ct_bus[0], 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      chk("bp_in_ready", in_ready[0], 1'b0);
      chk("bp_out_valid", out_valid[0], 1'b1);
      tick();
    end
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    chk("bp_release_out_valid", out_valid[0], 1'b0);
    chk("bp_release_in_ready", in_ready[0], 1'b1);
    tick();
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 400) begin tick(); lat++; end
    chk("blk2_lat_bp", lat, 50);
    chk("blk2_ct_bp", ct_bus[0], aes_ref(k, 4, p2));
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;

    // Key and block offered together in READY: the key wins.
    k = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    set_key(0, k);
    key_valid[0] = 1'b1;
    in_valid[0] = 1'b1;
    pt_bus[0] = 128'hffeeddccbbaa99887766554433221100;
    #1;
    chk("prio_in_ready", in_ready[0], 1'b0);
    tick();
    key_valid[0] = 1'b0;
    in_valid[0] = 1'b0;
    chk("prio_busy", busy[0], 1'b1);
    chk("prio_key_loaded", key_loaded[0], 1'b0);
    chk("prio_key_ready", key_ready[0], 1'b0);
    lat = 0;
    while (!key_loaded[0] && lat < 400) begin tick(); lat++; end
    chk("prio_kexp_lat", lat, 40);
    chk("prio_no_block", out_valid[0], 1'b0);
    p = {$urandom, $urandom, $urandom, $urandom};
    do_block(0, p, lat, c);
    chk("prio_ct", c, aes_ref(k, 4, p));

    // Random keys and blocks on every key length.
    for (int d = 0; d < 3; d++) begin
      for (int kk = 0; kk < 2; kk++) begin
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        do_key(d, k, lat);
        chk($sformatf("rnd_kexp_lat_d%0d", d), lat, 3*(4+2*d) + 28);
        for (int b = 0; b < 2; b++) begin
          p = {$urandom, $urandom, $urandom, $urandom};
          do_block(d, p, lat, c);
          chk($sformatf("rnd_blk_lat_d%0d", d), lat, 5*(10+2*d));
          chk($sformatf("rnd_ct_d%0d", d), c, aes_ref(k, 4+2*d, p));
        end
      end
    end

    // Reset during round 5 aborts and invalidates the schedule.
    p = {$urandom, $urandom, $urandom, $urandom};
    pt_bus[0] = p;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    for (int n = 0; n < 22; n++) tick();
    chk("midrst_busy_before", busy[0], 1'b1);
    rst_n = 1'b0;
    #2;
    chk("midrst_key_ready", key_ready[0], 1'b1);
    chk("midrst_in_ready", in_ready[0], 1'b0);
    chk("midrst_out_valid", out_valid[0], 1'b0);
    chk("midrst_ct", ct_bus[0], 128'h0);
    chk("midrst_key_loaded", key_loaded[0], 1'b0);
    chk("midrst_busy", busy[0], 1'b0);
    chk("midrst_key_loaded_d1", key_loaded[1], 1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    k = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    do_key(0, k, lat);
    chk("midrst_kexp_lat", lat, 40);
    do_block(0, p, lat, c);
    chk("midrst_blk_lat", lat, 50);
    chk("midrst_ct_after", c, aes_ref(k, 4, p));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/aes_enc_iter.md
Name: aes_enc_iter

Overview:
- Parametrised successor to the fixed AES-128 encrypt FSM.
- Iterative FIPS-197 encryption core supporting 128/192/256-bit keys, selected by parameter.
- Key expansion runs once per key load. The expanded schedule is stored internally and reused for any number of plaintext blocks.
- Valid/ready handshakes on key, input and output. Sits between the host register interface and the cipher-mode wrapper.

Parameters:
- KEY_BITS, 128, key length. Legal values: 128, 192, 256. Derived NK = KEY_BITS/32, NR = NK+6, NW = 4*(NR+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  key_in valid
- key_ready  out  1  core can accept a new key
- key_in  in  KEY_BITS  cipher key; MSB word is w[0], FIPS byte order
- in_valid  in  1  plaintext valid
- in_ready  out  1  core can accept a block
- plaintext  in  128  input block; [127:120] is FIPS byte 0
- out_valid  out  1  ciphertext valid
- out_ready  in  1  downstream accepts ciphertext
- ciphertext  out  128  result, same byte order as plaintext
- key_loaded  out  1  an expanded schedule is present
- busy  out  1  KEXP/SUB/MIX in progress

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values: key_ready=1, in_ready=0, out_valid=0, ciphertext=0, key_loaded=0, busy=0. State=IDLE, round=0, col=0, rcon=8'h01.
- States: IDLE (no key), KEXP, READY, SUB, MIX, DONE.
- key_ready=1 in IDLE and READY only.
- in_ready=1 in READY only, and only while key_valid=0. A key always has priority over a block.

Key handshake (IDLE/READY, key_valid & key_ready):
- w[0..NK-1] <= key_in, i <= NK, rcon <= 8'h01, key_loaded <= 0.
- Next state: KEXP.

KEXP (one word per cycle, i = NK..NW-1):
- temp = w[i-1].
- If i%NK==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, and rcon <= xtime(rcon).
- Else if NK==8 and i%NK==4: temp = SubWord(temp).
- w[i] <= w[i-NK] ^ temp.
- After w[NW-1] is written: key_loaded <= 1, next state READY.
- Duration: 40/46/52 cycles for 128/192/256.

Block handshake (READY, in_valid & in_ready):
- state <= plaintext ^ rk[0]; round <= 1; col <= 0; next state SUB.

SUB:
- Substitutes column col of state through the shared 4-byte S-box, one column per cycle.
- col wraps 3 to 0, then next state MIX.

MIX (1 cycle):
- state <= MixColumns(ShiftRows(state)) ^ rk[round].
- MixColumns is skipped when round==NR.
- If round==NR: ciphertext <= result, next state DONE. Otherwise round++ and next state SUB.

Latency:
- Block accept edge to out_valid rise is 5*NR cycles: 50/60/70.

DONE:
- out_valid=1; ciphertext is held stable.
- On out_ready, go to READY. out_valid drops the next cycle.
- There is no bypass: the next block is accepted no earlier than the cycle after out_ready.

S-box sharing:
- The 4-byte S-box is shared. KEXP and SUB are mutually exclusive, so a mux selects its input by state.

Boundary conditions:
- key_valid is ignored in KEXP/SUB/MIX/DONE.
- in_valid is ignored in IDLE and KEXP.
- A new key in READY discards the old schedule (key_loaded falls the next cycle).
- Reset mid-operation aborts everything immediately. The schedule is invalidated and a key must be reloaded.
- An illegal KEY_BITS value is an elaboration error.

Width rules:
- xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00).
- All state/key XORs are 128-bit and 32-bit bitwise.

Decomposition:
- Package aes_pkg holds:
  - the state enum;
  - the xtime, mixcolumn(32-bit) and shiftrows(128-bit) functions;
  - the KEY_BITS legality check and the NK/NR/NW derivation.
- Sub-module aes_sbox4: combinational 32-bit in/out, four FIPS S-box lookups. It is instantiated once.
- The round-key store is a local register array of NW x 32. It is not a separate module.

Test Plan:
- KEY_BITS=128: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32. key_loaded rises 40 cycles after key accept; out_valid rises 50 cycles after block accept.
- KEY_BITS=192 and 256 runs:
  - Key 000102..17 (192) -> ct dda97ca4864cdfe06eaf70a0ec0d7191.
  - Key 000102..1f (256) -> ct 8ea2b7ca516745bfeafc49904b496089.
  - Both use pt 00112233445566778899aabbccddeeff.
  - Latencies are 60 and 70 cycles.
- Key reuse and backpressure:
  - One key 000102..0f, two blocks back-to-back with out_ready held 0 for 10 cycles in DONE.
  - First ct 69c4e0d86a7b0430d8cdb78070b4c55a must stay stable; in_ready must stay 0 until the release.
  - The second block must also be correct.
- Priority: in READY, key_valid and in_valid asserted in the same cycle -> key accepted, block not accepted (in_ready=0), state goes to KEXP.
- Reset mid-operation: rst_n pulsed low during round 5 -> all outputs return to reset values and key_loaded=0. After reloading the key, a fresh encryption returns the correct ct.
- No key: in_valid held high in IDLE for 20 cycles -> in_ready=0 and out_valid=0 throughout.
